// File: rtl/exp_vec_accum_if.sv
// exp_vec_accum_if: sample-in / sum-out handshake bundle shared with the exp stage.
interface exp_vec_accum_if;
  logic [31:0] x;
  logic        i_valid;
  logic        i_rdy;
  logic        o_valid;
  logic        o_rdy;
  logic [31:0] y;
  logic        sat;
  modport master (output x, i_valid, i_rdy, input o_valid, o_rdy, y, sat);
  modport slave (input x, i_valid, i_rdy, output o_valid, o_rdy, y, sat);
endinterface

// File: rtl/exp_vec_accum.sv
// exp_vec_accum: sums each group of LEN sign-magnitude Q16.15 samples into one saturated scalar.
module exp_vec_accum #(
  parameter int LEN = 8
) (
  input logic             clk,
  input logic             rst_n,
  exp_vec_accum_if.slave  bus
);
  localparam int ACC_W = 33 + $clog2(LEN);
  localparam int CW = LEN > 1 ? $clog2(LEN) : 1;
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] OUTPUT = 1'b1;
  localparam logic signed [ACC_W-1:0] MAX = ACC_W'(32'h7fff_ffff);
  logic [0:0] state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, mag, smp, sum, abs_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] y_q, y_d;
  logic sat_q, sat_d, last, accept;
  assign bus.o_valid = state_q == OUTPUT;
  assign bus.o_rdy = state_q == ACCUM;
  assign bus.y = y_q;
  assign bus.sat = sat_q;
  always_comb begin
    mag = ACC_W'(bus.x[30:0]);
    smp = bus.x[31] ? -mag : mag;
    sum = acc_q + smp;
    abs_s = sum < 0 ? -sum : sum;
    last = cnt_q == CW'(LEN - 1);
    accept = state_q == ACCUM && bus.i_valid;
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    y_d = y_q;
    sat_d = sat_q;
    if (accept) begin
      acc_d = last ? '0 : sum;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        state_d = OUTPUT;
        sat_d = sum > MAX || sum < -MAX;
        // a zero sum has sign bit 0, so negative zero never leaves the block
        y_d = sum > MAX ? 32'h7fff_ffff : sum < -MAX ? 32'hffff_ffff : {sum < 0, abs_s[30:0]};
      end
    end else if (state_q == OUTPUT && bus.i_rdy) begin
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      y_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_exp_vec_accum.sv
// tb_exp_vec_accum: table vectors, hand-written corner sequences and random traffic vs a sum-of-samples model.
module tb_exp_vec_accum;
  localparam int LEN = 4;
  typedef struct {
    logic [31:0] xs [LEN];
    logic [31:0] ey;
    logic        esat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  exp_vec_accum_if bus ();
  exp_vec_accum #(.LEN(LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  longint q [$];
  bit m_out = 1'b0;
  logic [31:0] m_y = '0;
  bit m_sat = 1'b0;
  vec_t tbl [6];
  logic [31:0] hold_y;
  logic hold_sat;

  function automatic longint sval(logic [31:0] v);
    return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
  endfunction

  function automatic void conv(longint s, output logic [31:0] yo, output bit so);
    longint a;
    a = s < 0 ? -s : s;
    so = 1'b0;
    if (s > 64'sd2147483647) begin yo = 32'h7fff_ffff; so = 1'b1; end
    else if (s < -64'sd2147483647) begin yo = 32'hffff_ffff; so = 1'b1; end
    else yo = {s < 0, a[30:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit r, bit iv, logic [31:0] xv, bit ir);
    rst_n = r;
    bus.i_valid = iv;
    bus.x = xv;
    bus.i_rdy = ir;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_out = 1'b0;
      m_y = '0;
      m_sat = 1'b0;
    end else if (m_out) begin
      if (ir) m_out = 1'b0;
    end else if (iv) begin
      q.push_back(sval(xv));
      if (q.size() == LEN) begin
        longint s;
        s = 0;
        foreach (q[i]) s += q[i];
        conv(s, m_y, m_sat);
        q.delete();
        m_out = 1'b1;
      end
    end
    #1;
    chk("model_o_valid", 32'(bus.o_valid), 32'(m_out));
    chk("model_o_rdy", 32'(bus.o_rdy), 32'(!m_out));
    chk("model_y", bus.y, m_y);
    if (m_out) chk("model_sat", 32'(bus.sat), 32'(m_sat));
  endtask

  task automatic feed(logic [31:0] v, int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, v, 1'b1);
  endtask

  initial begin
    tbl[0] = '{xs: '{32'h0000_8000, 32'h0001_0000, 32'h0000_4000, 32'h0000_2000}, ey: 32'h0001_e000, esat: 1'b0};
    tbl[1] = '{xs: '{32'h0000_8000, 32'h8001_8000, 32'h0000_4000, 32'h8000_0000}, ey: 32'h8000_c000, esat: 1'b0};
    tbl[2] = '{xs: '{32'h0000_8000, 32'h8000_8000, 32'h8000_0000, 32'h0000_0000}, ey: 32'h0000_0000, esat: 1'b0};
    tbl[3] = '{xs: '{32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff}, ey: 32'h7fff_ffff, esat: 1'b1};
    tbl[4] = '{xs: '{32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff}, ey: 32'hffff_ffff, esat: 1'b1};
    tbl[5] = '{xs: '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000}, ey: 32'h0002_0000, esat: 1'b0};
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("rst_y", bus.y, 32'h0);
    chk("rst_o_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_o_rdy", 32'(bus.o_rdy), 32'h1);
    chk("rst_sat", 32'(bus.sat), 32'h0);
    foreach (tbl[t]) begin
      for (int i = 0; i < LEN; i++) begin
        chk("vec_pre_o_valid", 32'(bus.o_valid), 32'h0);
        cyc(1'b1, 1'b1, tbl[t].xs[i], 1'b1);
      end
      chk("vec_o_valid", 32'(bus.o_valid), 32'h1);
      chk("vec_o_rdy", 32'(bus.o_rdy), 32'h0);
      chk("vec_y", bus.y, tbl[t].ey);
      chk("vec_sat", 32'(bus.sat), 32'(tbl[t].esat));
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("vec_done_o_rdy", 32'(bus.o_rdy), 32'h1);
    end
    // back-pressure with garbage offered upstream
    feed(32'h0001_0000, LEN);
    hold_y = bus.y;
    hold_sat = bus.sat;
    chk("bp_y_first", hold_y, 32'h0004_0000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, $urandom, 1'b0);
      chk("bp_y_hold", bus.y, hold_y);
      chk("bp_sat_hold", 32'(bus.sat), 32'(hold_sat));
      chk("bp_o_rdy", 32'(bus.o_rdy), 32'h0);
    end
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    chk("bp_release_o_valid", 32'(bus.o_valid), 32'h0);
    feed(32'h0000_8000, LEN);
    chk("bp_next_y", bus.y, 32'h0002_0000);
    cyc(1'b1, 1'b0, '0, 1'b1);
    // upstream gaps
    foreach (tbl[0].xs[i]) ;
    begin
      bit pat [7];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      foreach (pat[i]) cyc(1'b1, pat[i], 32'h0000_8000, 1'b1);
    end
    chk("gap_o_valid", 32'(bus.o_valid), 32'h1);
    chk("gap_y", bus.y, 32'h0002_0000);
    cyc(1'b1, 1'b0, '0, 1'b1);
    // reset mid-vector discards the partial sum
    feed(32'h0001_0000, 2);
    cyc(1'b0, 1'b0, '0, 1'b1);
    feed(32'h0000_4000, LEN);
    chk("rst_mid_y", bus.y, 32'h0001_0000);
    chk("rst_mid_o_valid", 32'(bus.o_valid), 32'h1);
    // reset during output
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("rst_out_o_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_out_y", bus.y, 32'h0);
    chk("rst_out_o_rdy", 32'(bus.o_rdy), 32'h1);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] xv;
      xv = $urandom;
      case ($urandom_range(0, 7))
        0: xv = 32'h7fff_ffff;
        1: xv = 32'h8000_0000;
        2: xv = $urandom_range(0, 1) != 0 ? 32'hffff_ffff : 32'h0;
        3, 4: ;
        default: xv[30:17] = '0;
      endcase
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, xv, $urandom_range(0, 2) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
